// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM states, memory sizing, NOP encoding.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FETCH,
        HALT
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic int mem_bytes(input int no_of_regs);
        return no_of_regs * 4;
    endfunction

endpackage

// File: rtl/fetch_boot_loader.sv
// Boot loader write pointer and handshake; accepts one word per cycle while active.
// Signals completion on the last flagged word or when the final memory word is written.
module fetch_boot_loader
    import fetch_pkg::*;
#(
    parameter int REG_SIZE  = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                active_i,
    input  logic                ld_valid_i,
    input  logic                ld_last_i,
    output logic                ld_ready_o,
    output logic [REG_SIZE-1:0] ld_ptr_o,
    output logic                done_o
);

    logic [REG_SIZE-1:0] ld_ptr_q, ld_ptr_d, ld_ptr_nxt;
    logic                accept;

    assign ld_ready_o = active_i;
    assign accept     = active_i & ld_valid_i;
    assign ld_ptr_nxt = ld_ptr_q + REG_SIZE'(4);
    assign done_o     = accept & (ld_last_i | (ld_ptr_nxt == REG_SIZE'(MEM_BYTES)));
    assign ld_ptr_o   = ld_ptr_q;

    // Rewind on completion so a later boot always starts from word 0.
    always_comb begin
        ld_ptr_d = ld_ptr_q;
        if (done_o) begin
            ld_ptr_d = '0;
        end else if (accept) begin
            ld_ptr_d = ld_ptr_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_ptr_q <= '0;
        end else begin
            ld_ptr_q <= ld_ptr_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, shares the imem port with the boot loader, drives IF/ID.
// One cycle from mem_addr_o to inst_o; stall holds IF/ID, branch inserts one bubble, faults halt.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                  REG_SIZE       = 32,
    parameter int                  MEM_SIZE_IN_KB = 1,
    parameter int                  NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
    parameter logic [REG_SIZE-1:0] RESET_PC       = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                boot_en_i,
    input  logic                ld_valid_i,
    input  logic [REG_SIZE-1:0] ld_data_i,
    input  logic                ld_last_i,
    output logic                ld_ready_o,
    output logic [REG_SIZE-1:0] mem_addr_o,
    output logic                mem_we_o,
    output logic [REG_SIZE-1:0] mem_wdata_o,
    input  logic [REG_SIZE-1:0] mem_rdata_i,
    input  logic                stall_i,
    input  logic                br_taken_i,
    input  logic [REG_SIZE-1:0] br_target_i,
    output logic [REG_SIZE-1:0] pc_o,
    output logic [REG_SIZE-1:0] inst_o,
    output logic                inst_valid_o,
    output logic                boot_done_o,
    output logic                err_o
);

    localparam int                  MEM_BYTES_I = mem_bytes(NO_OF_REGS);
    localparam logic [REG_SIZE-1:0] MEM_BYTES   = REG_SIZE'(MEM_BYTES_I);
    localparam logic [REG_SIZE-1:0] LAST_PC     = MEM_BYTES - REG_SIZE'(4);

    fetch_state_e        state_q;
    logic [REG_SIZE-1:0] pc_q, pc_o_q, inst_q;
    logic                inst_valid_q, boot_done_q, err_q;
    logic [REG_SIZE-1:0] ld_ptr;
    logic                ld_done, loading, br_bad;

    assign loading = (state_q == LOAD);
    assign br_bad  = (br_target_i[1:0] != 2'b00) || (br_target_i >= MEM_BYTES);

    fetch_boot_loader #(
        .REG_SIZE  (REG_SIZE),
        .MEM_BYTES (MEM_BYTES_I)
    ) u_loader (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .active_i   (loading),
        .ld_valid_i (ld_valid_i),
        .ld_last_i  (ld_last_i),
        .ld_ready_o (ld_ready_o),
        .ld_ptr_o   (ld_ptr),
        .done_o     (ld_done)
    );

    assign mem_addr_o   = loading ? ld_ptr : pc_q;
    assign mem_we_o     = loading & ld_valid_i;
    assign mem_wdata_o  = ld_data_i;
    assign pc_o         = pc_o_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = inst_valid_q;
    assign boot_done_o  = boot_done_q;
    assign err_o        = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pc_o_q       <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            boot_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pc_q        <= RESET_PC;
                    state_q     <= boot_en_i ? LOAD : FETCH;
                    boot_done_q <= !boot_en_i;
                end
                LOAD: begin
                    if (ld_done) begin
                        state_q     <= FETCH;
                        pc_q        <= RESET_PC;
                        boot_done_q <= 1'b1;
                    end
                end
                FETCH: begin
                    // A redirect outranks a stall so hazards can never swallow a branch.
                    if (br_taken_i) begin
                        inst_valid_q <= 1'b0;
                        if (br_bad) begin
                            state_q <= HALT;
                            err_q   <= 1'b1;
                        end else begin
                            pc_q <= br_target_i;
                        end
                    end else if (!stall_i) begin
                        pc_o_q       <= pc_q;
                        inst_q       <= mem_rdata_i;
                        inst_valid_q <= 1'b1;
                        pc_q         <= pc_q + REG_SIZE'(4);
                        if (pc_q == LAST_PC) begin
                            state_q <= HALT;
                            err_q   <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    inst_valid_q <= 1'b0;
                    err_q        <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized stall/branch run against a PC-stream model.
module tb_fetch_ctrl;

    localparam int WORDS = 256;
    localparam int MEMB  = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_en, ld_valid, ld_last, ld_ready;
    logic [31:0] ld_data, mem_addr, mem_wdata, mem_rdata, br_target, pc_o, inst_o;
    logic        mem_we, stall, br_taken, inst_valid, boot_done, err;

    logic [31:0] imem    [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_dat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .boot_en_i    (boot_en),
        .ld_valid_i   (ld_valid),
        .ld_data_i    (ld_data),
        .ld_last_i    (ld_last),
        .ld_ready_o   (ld_ready),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .stall_i      (stall),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid),
        .boot_done_o  (boot_done),
        .err_o        (err)
    );

    always @(posedge clk) begin
        if (bd_we) imem[bd_idx] <= bd_dat;
        else if (mem_we && mem_addr < 32'(MEMB)) imem[mem_addr[9:2]] <= mem_wdata;
    end
    assign mem_rdata = (mem_addr < 32'(MEMB)) ? imem[mem_addr[9:2]] : 32'h0;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        stall = 0; br_taken = 0; br_target = 0; ld_valid = 0; ld_last = 0; ld_data = 0;
    endtask

    task automatic do_reset(input logic boot);
        rst_n = 0; boot_en = boot; idle_inputs();
        step();
        rst_n = 1;
        step();
    endtask

    task automatic preload();
        rst_n = 0;
        for (int i = 0; i < WORDS; i++) begin
            bd_we = 1; bd_idx = 8'(i); bd_dat = $urandom; ref_mem[i] = bd_dat;
            step();
        end
        bd_we = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; boot_en = 1; stall = 1; br_taken = 1; br_target = 32'h40; ld_valid = 1;
        #1;
        if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
        checks++;
        if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst_o); end
        checks++;
        if ({inst_valid, boot_done, err, ld_ready, mem_we} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {inst_valid, boot_done, err, ld_ready, mem_we});
        end
        checks++;
        step();
        if ({inst_valid, err, ld_ready} !== 3'b0) begin
            errors++; $display("FAIL reset_hold got=%b exp=000", {inst_valid, err, ld_ready});
        end
        checks++;
    endtask

    task automatic test_fetch_seq();
        do_reset(0);
        if (boot_done !== 1'b1 || ld_ready !== 1'b0) begin
            errors++; $display("FAIL seq_boot_done got=%b%b exp=10", boot_done, ld_ready);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (pc_o !== 32'(i * 4) || inst_o !== ref_mem[i] || inst_valid !== 1'b1) begin
                errors++; $display("FAIL seq_%0d got pc=%h inst=%h v=%b exp pc=%h inst=%h v=1",
                                   i, pc_o, inst_o, inst_valid, i * 4, ref_mem[i]);
            end
            checks++;
        end
    endtask

    task automatic test_boot();
        logic [31:0] w [3];
        logic        vsched [5];
        int          n = 0;
        w = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003};
        vsched = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset(1);
        if (ld_ready !== 1'b1 || boot_done !== 1'b0) begin
            errors++; $display("FAIL boot_ready got=%b%b exp=10", ld_ready, boot_done);
        end
        checks++;
        for (int k = 0; k < 5; k++) begin
            ld_valid = vsched[k];
            ld_data  = vsched[k] ? w[n] : 32'hDEAD_BEEF;
            ld_last  = vsched[k] && (n == 2);
            #1;
            if (mem_we !== vsched[k] || (vsched[k] && mem_addr !== 32'(n * 4))) begin
                errors++; $display("FAIL boot_write_%0d got we=%b addr=%h exp we=%b addr=%h",
                                   k, mem_we, mem_addr, vsched[k], n * 4);
            end
            checks++;
            if (vsched[k]) n++;
            step();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) ref_mem[i] = w[i];
        for (int i = 0; i < 4; i++) begin
            if (imem[i] !== ref_mem[i]) begin
                errors++; $display("FAIL boot_mem_%0d got=%h exp=%h", i, imem[i], ref_mem[i]);
            end
            checks++;
        end
        #1;
        if (boot_done !== 1'b1 || ld_ready !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL boot_done got=%b%b%b exp=100", boot_done, ld_ready, mem_we);
        end
        checks++;
        step();
        if (pc_o !== 32'h0 || inst_o !== 32'hAAAA0001 || inst_valid !== 1'b1) begin
            errors++; $display("FAIL boot_first got pc=%h inst=%h v=%b exp pc=0 inst=aaaa0001 v=1",
                               pc_o, inst_o, inst_valid);
        end
        checks++;
    endtask

    task automatic test_stall();
        do_reset(0);
        step(); step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (pc_o !== 32'h4 || inst_o !== ref_mem[1] || inst_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold_%0d got pc=%h inst=%h v=%b exp pc=4 inst=%h v=1",
                                   i, pc_o, inst_o, inst_valid, ref_mem[1]);
            end
            checks++;
        end
        stall = 0;
        for (int i = 2; i < 4; i++) begin
            step();
            if (pc_o !== 32'(i * 4) || inst_o !== ref_mem[i] || inst_valid !== 1'b1) begin
                errors++; $display("FAIL stall_resume_%0d got pc=%h inst=%h exp pc=%h inst=%h",
                                   i, pc_o, inst_o, i * 4, ref_mem[i]);
            end
            checks++;
        end
    endtask

    task automatic test_branch_stall();
        do_reset(0);
        step(); step(); step();
        br_taken = 1; br_target = 32'h40; stall = 1;
        step();
        br_taken = 0; stall = 0;
        if (inst_valid !== 1'b0 || pc_o !== 32'h8 || inst_o !== ref_mem[2]) begin
            errors++; $display("FAIL br_bubble got pc=%h v=%b exp pc=8 v=0", pc_o, inst_valid);
        end
        checks++;
        step();
        if (pc_o !== 32'h40 || inst_o !== ref_mem[16] || inst_valid !== 1'b1) begin
            errors++; $display("FAIL br_target got pc=%h inst=%h v=%b exp pc=40 inst=%h v=1",
                               pc_o, inst_o, inst_valid, ref_mem[16]);
        end
        checks++;
    endtask

    task automatic test_halt(input logic [31:0] tgt);
        do_reset(0);
        step();
        br_taken = 1; br_target = tgt;
        step();
        br_taken = 0;
        if (err !== 1'b1 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL halt_%h_entry got err=%b v=%b exp err=1 v=0", tgt, err, inst_valid);
        end
        checks++;
        for (int i = 0; i < 5; i++) begin
            stall = 1'($urandom); br_taken = 1'($urandom); br_target = 32'h10;
            ld_valid = 1'($urandom); boot_en = 1'($urandom);
            step();
            if (err !== 1'b1 || inst_valid !== 1'b0 || mem_we !== 1'b0 || ld_ready !== 1'b0) begin
                errors++; $display("FAIL halt_%h_sticky_%0d got err=%b v=%b we=%b rdy=%b exp 1000",
                                   tgt, i, err, inst_valid, mem_we, ld_ready);
            end
            checks++;
        end
        #2; rst_n = 0; #1;
        if (err !== 1'b0) begin errors++; $display("FAIL halt_%h_clear got err=%b exp=0", tgt, err); end
        checks++;
        idle_inputs();
    endtask

    task automatic test_runoff();
        do_reset(0);
        step();
        br_taken = 1; br_target = 32'h3F8;
        step();
        br_taken = 0;
        step();
        step();
        if (pc_o !== 32'h3FC || inst_o !== ref_mem[255] || inst_valid !== 1'b1) begin
            errors++; $display("FAIL runoff_last got pc=%h inst=%h v=%b exp pc=3fc inst=%h v=1",
                               pc_o, inst_o, inst_valid, ref_mem[255]);
        end
        checks++;
        step();
        if (err !== 1'b1 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL runoff_halt got err=%b v=%b exp err=1 v=0", err, inst_valid);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [31:0] m_pc, e_pc, e_inst;
        logic        e_vld;
        logic        r_br, r_st;
        logic [31:0] r_tgt;
        int          bad = 0;
        m_pc = 0; e_pc = 0; e_inst = 0; e_vld = 0;
        do_reset(0);
        for (int c = 0; c < 150; c++) begin
            r_st  = ($urandom_range(0, 9) < 3);
            r_br  = ($urandom_range(0, 9) == 0);
            r_tgt = 32'($urandom_range(0, 64)) * 4;
            stall = r_st; br_taken = r_br; br_target = r_tgt;
            step();
            if (r_br) begin
                m_pc  = r_tgt;
                e_vld = 0;
            end else if (!r_st) begin
                e_pc   = m_pc;
                e_inst = ref_mem[m_pc[9:2]];
                e_vld  = 1;
                m_pc   = m_pc + 4;
            end
            if (pc_o !== e_pc || inst_o !== e_inst || inst_valid !== e_vld) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL rand_cycle_%0d got pc=%h inst=%h v=%b exp pc=%h inst=%h v=%b",
                                      c, pc_o, inst_o, inst_valid, e_pc, e_inst, e_vld);
            end
            checks++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_midload();
        logic [31:0] d [2];
        logic [31:0] x;
        do_reset(1);
        for (int i = 0; i < 2; i++) begin
            d[i] = $urandom; ld_valid = 1; ld_data = d[i];
            step();
        end
        #2; rst_n = 0; #1;
        if (ld_ready !== 1'b0 || mem_we !== 1'b0 || boot_done !== 1'b0 || inst_valid !== 1'b0 ||
            err !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL midload_reset got rdy=%b we=%b bd=%b v=%b err=%b pc=%h addr=%h exp all 0",
                               ld_ready, mem_we, boot_done, inst_valid, err, pc_o, mem_addr);
        end
        checks++;
        if (imem[0] !== d[0] || imem[1] !== d[1]) begin
            errors++; $display("FAIL midload_mem got=%h %h exp=%h %h", imem[0], imem[1], d[0], d[1]);
        end
        checks++;
        ld_valid = 0;
        step();
        rst_n = 1; boot_en = 1;
        step();
        x = $urandom; ld_valid = 1; ld_data = x;
        #1;
        if (mem_addr !== 32'h0 || mem_we !== 1'b1) begin
            errors++; $display("FAIL midload_restart got addr=%h we=%b exp addr=0 we=1", mem_addr, mem_we);
        end
        checks++;
        step();
        ld_valid = 0;
        if (imem[0] !== x) begin errors++; $display("FAIL midload_rewrite got=%h exp=%h", imem[0], x); end
        checks++;
    endtask

    initial begin
        rst_n = 1; boot_en = 0; bd_we = 0; bd_idx = 0; bd_dat = 0;
        idle_inputs();
        #2;
        preload();
        test_reset();
        test_fetch_seq();
        test_boot();
        test_stall();
        test_branch_stall();
        test_halt(32'h42);
        test_halt(32'h400);
        test_runoff();
        test_random();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage controller for the 3-stage RISC-V pipeline; owns the PC and sequences the instruction memory.
- Shares the memory address port between a boot loader (write path) and instruction fetch (combinational read path).
- Drives the IF/ID register (pc_o, inst_o, inst_valid_o) and applies stall, branch redirect and error halt.

Parameters:
- REG_SIZE, 32, data/address width
- MEM_SIZE_IN_KB, 1, instruction memory size
- NO_OF_REGS, MEM_SIZE_IN_KB*1024/4, number of 32-bit words
- RESET_PC, 0, first fetch address after boot

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- boot_en_i  in  1  sampled in IDLE: 1 = run loader first
- ld_valid_i  in  1  loader word valid
- ld_data_i  in  REG_SIZE  loader word
- ld_last_i  in  1  final loader word
- ld_ready_o  out  1  loader may transfer
- mem_addr_o  out  REG_SIZE  byte address to inst_mem addr_i
- mem_we_o  out  1  inst_mem write enable
- mem_wdata_o  out  REG_SIZE  inst_mem write data
- mem_rdata_i  in  REG_SIZE  inst_mem inst_o (combinational)
- stall_i  in  1  hold fetch stage (hazard)
- br_taken_i  in  1  redirect request from execute
- br_target_i  in  REG_SIZE  redirect byte address
- pc_o  out  REG_SIZE  IF/ID PC
- inst_o  out  REG_SIZE  IF/ID instruction
- inst_valid_o  out  1  IF/ID valid
- boot_done_o  out  1  loader finished / fetch running
- err_o  out  1  sticky fault (misaligned or out-of-range PC)

Behaviour:
- Reset values: state=IDLE, pc_q=RESET_PC, ld_ptr=0, pc_o=0, inst_o=0 (NOP encoding not required), inst_valid_o=0, boot_done_o=0, err_o=0.
- Reset applies immediately from any state, including mid-load; partially written memory is left as-is.
- MEM_BYTES = NO_OF_REGS*4. All addresses are byte addresses; words are 4-byte aligned.
- IDLE (1 cycle): boot_en_i=1 -> LOAD, else -> FETCH.
- LOAD:
  - ld_ready_o=1, mem_addr_o=ld_ptr, mem_wdata_o=ld_data_i, mem_we_o=ld_valid_i.
  - On each accepted word: ld_ptr += 4.
  - Accepted word with ld_last_i=1, or ld_ptr+4 == MEM_BYTES -> FETCH, with pc_q=RESET_PC.
  - ld_valid_i=0 inserts wait cycles with no write.
- FETCH:
  - mem_addr_o=pc_q, mem_we_o=0, ld_ready_o=0, boot_done_o=1.
  - Priority per clock, highest first:
    1. br_taken_i: if br_target_i[1:0]!=0 or br_target_i>=MEM_BYTES -> HALT; else pc_q<=br_target_i, inst_valid_o<=0 (one bubble). pc_o/inst_o hold.
    2. stall_i: pc_q, pc_o, inst_o, inst_valid_o all hold.
    3. Normal: pc_o<=pc_q, inst_o<=mem_rdata_i, inst_valid_o<=1, pc_q<=pc_q+4.
  - Run-off end: a normal advance from pc_q=MEM_BYTES-4 still registers that last instruction, then -> HALT.
  - Branch and stall in the same cycle: the branch wins; a stall never blocks a redirect.
- HALT:
  - err_o=1 (sticky), inst_valid_o=0, mem_we_o=0, ld_ready_o=0.
  - Inputs are ignored; the only exit is reset.
- Latency: one cycle from mem_addr_o to registered inst_o; the first valid instruction appears 1 cycle after entering FETCH.
- PC arithmetic is REG_SIZE unsigned; no wrap-around to 0.

Decomposition:
- Package fetch_pkg: state enum (IDLE, LOAD, FETCH, HALT), MEM_BYTES derivation, NOP constant 32'h00000013.
- Optional sub-module fetch_boot_loader (ld_ptr counter + handshake); the FSM and IF/ID register stay in fetch_ctrl.

Test Plan:
- Reset with boot_en_i=0, no stall -> IDLE, then FETCH; pc_o = 0,4,8,12 on consecutive cycles with inst_valid_o=1 and inst_o = memory words 0..3.
- boot_en_i=1; load 3 words 0xAAAA0001..3 with a 2-cycle ld_valid_i gap, last word flagged ld_last_i -> writes at addresses 0,4,8 only; then fetch returns 0xAAAA0001 at pc_o=0.
- stall_i high for 3 cycles at pc_q=8 -> pc_o/inst_o frozen at 4, then resume at 8 with no lost or duplicated instruction.
- br_taken_i with br_target_i=0x40 asserted together with stall_i -> next cycle inst_valid_o=0, following cycle pc_o=0x40, valid=1.
- br_target_i=0x42, and separately br_target_i=0x400 (1 KB) -> HALT, err_o=1, inst_valid_o=0 until rst_ni low.
- Assert rst_ni low mid-LOAD after 2 words -> all outputs return to reset values immediately (asynchronously); next boot restarts at ld_ptr=0.
